// File: rtl/sn_window_accum.sv
// Stochastic window accumulator: ANDs four stochastic lanes with bit-reversed weight
// streams, counts ones over a window of up to 16 cycles and holds the result for the consumer.
module sn_window_accum #(
  parameter int N_LANE  = 4,
  parameter int WIN_LEN = 16
) (
  input  logic             i_clk_fsm_mux,
  input  logic             i_rst_fsm_mux,
  input  logic             i_isgen,
  input  logic             i_sn_bit   [N_LANE-1:0],
  input  logic [3:0]       i_w_bn     [N_LANE-1:0],
  input  logic             i_ready,
  output logic             o_valid,
  output logic [3:0]       o_lane_cnt [N_LANE-1:0],
  output logic [5:0]       o_sum,
  output logic             o_ovf,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [3:0] LAST_IDX = 4'(WIN_LEN - 1);

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] acc_q [N_LANE-1:0];
  logic [3:0] acc_d [N_LANE-1:0];
  logic [3:0] w_q   [N_LANE-1:0];
  logic [3:0] w_d   [N_LANE-1:0];
  logic [3:0] cnt_q [N_LANE-1:0];
  logic [3:0] cnt_d [N_LANE-1:0];
  logic [5:0] sum_q, sum_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;
  logic       busy_q, busy_d;

  logic [3:0] acc_inc_s [N_LANE-1:0];
  logic [3:0] fin_s     [N_LANE-1:0];
  logic [3:0] wk_s;
  logic [5:0] fin_sum_s;
  logic       commit_s;

  // Next-state, accumulation and result-buffer logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    commit_s  = 1'b0;
    fin_s     = acc_q;
    fin_sum_s = 6'd0;
    wk_s      = 4'd0;

    // The first window bit uses the incoming weights, before they are registered
    for (int k = 0; k < N_LANE; k++) begin
      if (state_q == IDLE) begin
        wk_s = i_w_bn[k];
      end else begin
        wk_s = w_q[k];
      end
      acc_inc_s[k] = acc_q[k] + {3'd0, i_sn_bit[k] & (wk_s > bitrev4(idx_q))};
    end

    case (state_q)
      IDLE: begin
        if (i_isgen) begin
          w_d     = i_w_bn;
          acc_d   = acc_inc_s;
          idx_d   = 4'd1;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (i_isgen) begin
          if (idx_q == LAST_IDX) begin
            fin_s    = acc_inc_s;
            commit_s = 1'b1;
            state_d  = DRAIN;
          end else begin
            acc_d = acc_inc_s;
            idx_d = idx_q + 4'd1;
          end
        end else begin
          fin_s    = acc_q;
          commit_s = 1'b1;
          state_d  = IDLE;
        end
      end
      DRAIN: begin
        if (!i_isgen) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int k = 0; k < N_LANE; k++) begin
      fin_sum_s = fin_sum_s + {2'd0, fin_s[k]};
    end

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // A commit may reuse the slot being read on the same edge
    if (commit_s) begin
      idx_d = 4'd0;
      for (int k = 0; k < N_LANE; k++) begin
        acc_d[k] = 4'd0;
      end
      if (!valid_q || i_ready) begin
        cnt_d   = fin_s;
        sum_d   = fin_sum_s;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      ovf_d = ovf_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
    if (i_rst_fsm_mux) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      sum_q   <= 6'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < N_LANE; k++) begin
        acc_q[k] <= 4'd0;
        w_q[k]   <= 4'd0;
        cnt_q[k] <= 4'd0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_lane_cnt = cnt_q;
  assign o_sum      = sum_q;
  assign o_ovf      = ovf_q;
  assign o_busy     = busy_q;

endmodule
